// File: rtl/banked_regfile_ctx_pkg.sv
// regfile_pkg: copy FSM state type and default sizing shared by banked_regfile_ctx and regfile_copy_ctrl
package regfile_pkg;
  typedef enum logic [1:0] {IDLE, COPY, DONE} copy_state_t;
  localparam int DEF_DATA_W = 10;
  localparam int DEF_REGS = 4;
  localparam int DEF_BANKS = 2;
endpackage

// File: rtl/banked_regfile_ctx_copy_ctrl.sv
// regfile_copy_ctrl: bank-copy FSM and word index.
// Ports: clk, rst (sync, active-high); copy_req/copy_src/copy_dst request; stall (external write this cycle);
//   copy_busy/copy_done/copy_err status; copy_we, src, dst, idx drive the storage copy write.
module regfile_copy_ctrl import regfile_pkg::*; #(
  parameter int REGS = DEF_REGS,
  parameter int BANKS = DEF_BANKS,
  localparam int AW = $clog2(REGS),
  localparam int BW = $clog2(BANKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          copy_req,
  input  logic [BW-1:0] copy_src,
  input  logic [BW-1:0] copy_dst,
  input  logic          stall,
  output logic          copy_busy,
  output logic          copy_done,
  output logic          copy_err,
  output logic          copy_we,
  output logic [BW-1:0] src,
  output logic [BW-1:0] dst,
  output logic [AW-1:0] idx
);
  copy_state_t state, nxt;
  logic ok;
  always_comb begin
    ok = 32'(copy_src) < BANKS && 32'(copy_dst) < BANKS;
    nxt = state == IDLE ? (copy_req && ok ? (copy_src == copy_dst ? DONE : COPY) : IDLE)
        : state == COPY ? (!stall && idx == AW'(REGS - 1) ? DONE : COPY)
        : IDLE;
    copy_busy = state == COPY;
    copy_done = state == DONE;
    copy_we = copy_busy && !stall;
  end
  // src/dst latched on any IDLE request so later input changes cannot steer an active copy
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      src <= '0;
      dst <= '0;
      copy_err <= 1'b0;
    end else begin
      state <= nxt;
      copy_err <= state == IDLE && copy_req && !ok;
      idx <= copy_we ? idx + 1'b1 : state == COPY ? idx : '0;
      if (state == IDLE && copy_req) begin
        src <= copy_src;
        dst <= copy_dst;
      end
    end
  end
endmodule

// File: rtl/banked_regfile_ctx.sv
// banked_regfile_ctx: BANKS x REGS register file with two read ports and a background bank-copy engine.
// Ports: clk, rst (sync, active-high); we/wbank/waddr/wdata external write; rbank/raddr1/raddr2 -> rdata1/rdata2
//   (combinational); copy_req/copy_src/copy_dst request a bank copy; copy_busy/copy_done/copy_err status.
// Define REGFILE_BYPASS_EN to forward the write taking effect this edge to matching reads.
module banked_regfile_ctx import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REGS = DEF_REGS,
  parameter int BANKS = DEF_BANKS,
  localparam int AW = $clog2(REGS),
  localparam int BW = $clog2(BANKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [BW-1:0]     wbank,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BW-1:0]     rbank,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              copy_req,
  input  logic [BW-1:0]     copy_src,
  input  logic [BW-1:0]     copy_dst,
  output logic              copy_busy,
  output logic              copy_done,
  output logic              copy_err
);
  logic [DATA_W-1:0] mem [BANKS][REGS];
  logic copy_we, wr_en, rvalid;
  logic [BW-1:0] src, dst, wr_bank;
  logic [AW-1:0] idx, wr_addr;
  logic [DATA_W-1:0] wr_data;
  regfile_copy_ctrl #(.REGS(REGS), .BANKS(BANKS)) u_ctrl (
    .clk(clk),
    .rst(rst),
    .copy_req(copy_req),
    .copy_src(copy_src),
    .copy_dst(copy_dst),
    .stall(we),
    .copy_busy(copy_busy),
    .copy_done(copy_done),
    .copy_err(copy_err),
    .copy_we(copy_we),
    .src(src),
    .dst(dst),
    .idx(idx)
  );
  // One shared write port: the external write wins, the copy engine only writes when it is not stalled
  always_comb begin
    wr_en = (we && 32'(wbank) < BANKS) || copy_we;
    wr_bank = we ? wbank : dst;
    wr_addr = we ? waddr : idx;
    wr_data = we ? wdata : mem[src][idx];
    rvalid = 32'(rbank) < BANKS;
`ifdef REGFILE_BYPASS_EN
    rdata1 = !rvalid ? '0 : wr_en && wr_bank == rbank && wr_addr == raddr1 ? wr_data : mem[rbank][raddr1];
    rdata2 = !rvalid ? '0 : wr_en && wr_bank == rbank && wr_addr == raddr2 ? wr_data : mem[rbank][raddr2];
`else
    rdata1 = rvalid ? mem[rbank][raddr1] : '0;
    rdata2 = rvalid ? mem[rbank][raddr2] : '0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < BANKS; b++)
        for (int a = 0; a < REGS; a++)
          mem[b][a] <= '0;
    end else if (wr_en) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end
endmodule
